// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph codes (active-low, bit 6 = g .. bit 0 = a) and display modes for the scan controller
package seg7_pkg;
  typedef enum logic [1:0] {
    MODE_NUM  = 2'd0,
    MODE_MAX  = 2'd1,
    MODE_DASH = 2'd2,
    MODE_RAW  = 2'd3
  } mode_e;
  localparam logic [6:0] GLYPH_OFF  = 7'b1111111;
  localparam logic [6:0] GLYPH_DASH = 7'b0111111;
  localparam logic [6:0] GLYPH_M    = 7'b1101010;
  localparam logic [6:0] GLYPH_A    = 7'b0001000;
  localparam logic [6:0] GLYPH_X    = 7'b0001001;
  localparam logic [9:0][6:0] GLYPH_DIGIT = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD nibble to active-low glyph; non-decimal codes show a dash
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] glyph
);
  always_comb glyph = (bcd > 4'd9) ? GLYPH_DASH : GLYPH_DIGIT[bcd];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: N-digit multiplexed 7-segment scanner with frame-synchronous content, blink and PWM dimming
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int BLINK_DIV  = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  mode_e                 mode,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [7*N_DIGITS-1:0] raw_seg,
  input  logic [N_DIGITS-1:0]   blink_en,
  input  logic                  blank_lz,
  input  logic [3:0]            bright,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);
  localparam int DIV = CLK_HZ / REFRESH_HZ;
  localparam int TW  = $clog2(DIV);
  localparam int SW  = $clog2(N_DIGITS);
  localparam int BW  = $clog2(BLINK_DIV + 1);

  if (N_DIGITS < 3 || N_DIGITS > 8 || DIV < 16) begin : g_param_check
    $error("seg7_scan_ctrl: N_DIGITS must be 3..8 and CLK_HZ/REFRESH_HZ at least 16");
  end

  typedef struct packed {
    mode_e                 mode;
    logic [4*N_DIGITS-1:0] value;
    logic [7*N_DIGITS-1:0] raw;
    logic [N_DIGITS-1:0]   blink;
    logic                  blz;
  } disp_t;

  localparam disp_t DISP_RST = '{mode: MODE_DASH, value: '0, raw: '0, blink: '0, blz: 1'b0};

  logic [TW-1:0]       timer_q, timer_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic                phase_q, phase_d;
  disp_t               p_q, p_d, c_q, c_d;
  logic                p_valid_q, p_valid_d;
  logic                wrap_q, wrap_d;
  logic                fd_q, fd_d;
  logic [6:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;

  logic                slot_end, wrap, commit, blink_end, pwm_on, zero_above;
  logic [N_DIGITS-1:0] lz_off;
  logic [3:0]          cur_bcd;
  logic [6:0]          dec_glyph, max_glyph, raw_glyph, base_glyph;
  logic [31:0]         pwm_thr;

  always_comb cur_bcd = c_q.value[4*int'(sel_q) +: 4];

  seg7_decode u_decode (
    .bcd  (cur_bcd),
    .glyph(dec_glyph)
  );

  always_comb begin
    slot_end  = timer_q == TW'(DIV - 1);
    wrap      = slot_end && sel_q == SW'(N_DIGITS - 1);
    // a load landing on the wrap edge replaces the pending content instead of committing it
    commit    = wrap && p_valid_q && !load;
    blink_end = bcnt_q == BW'(BLINK_DIV - 1);
    timer_d   = slot_end ? '0 : timer_q + 1'b1;
    sel_d     = wrap ? '0 : slot_end ? sel_q + 1'b1 : sel_q;
    bcnt_d    = blink_end ? '0 : bcnt_q + 1'b1;
    phase_d   = blink_end ? !phase_q : phase_q;
    p_d       = load ? disp_t'({mode, value, raw_seg, blink_en, blank_lz}) : p_q;
    p_valid_d = load || (p_valid_q && !wrap);
    c_d       = commit ? p_q : c_q;
    wrap_d    = wrap;
    fd_d      = wrap_q;
    zero_above = c_q.blz;
    lz_off     = '0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && c_q.value[4*i +: 4] == 4'd0;
      lz_off[i]  = zero_above;
    end
    max_glyph  = sel_q == SW'(N_DIGITS - 1) ? GLYPH_M :
                 sel_q == SW'(N_DIGITS - 2) ? GLYPH_A :
                 sel_q == SW'(N_DIGITS - 3) ? GLYPH_X : GLYPH_OFF;
    raw_glyph  = c_q.raw[7*int'(sel_q) +: 7];
    base_glyph = c_q.mode == MODE_NUM ? (lz_off[sel_q] ? GLYPH_OFF : dec_glyph) :
                 c_q.mode == MODE_MAX ? max_glyph :
                 c_q.mode == MODE_RAW ? raw_glyph : GLYPH_DASH;
    seg_d      = phase_q && c_q.blink[sel_q] ? GLYPH_OFF : base_glyph;
    pwm_thr    = ((32'(bright) + 32'd1) * 32'(DIV)) >> 4;
    pwm_on     = 32'(timer_q) < pwm_thr;
    an_d       = pwm_on ? ~(N_DIGITS'(1) << sel_q) : '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q   <= '0;
      sel_q     <= '0;
      bcnt_q    <= '0;
      phase_q   <= 1'b0;
      p_q       <= DISP_RST;
      c_q       <= DISP_RST;
      p_valid_q <= 1'b0;
      wrap_q    <= 1'b0;
      fd_q      <= 1'b0;
      seg_q     <= GLYPH_OFF;
      an_q      <= '1;
    end else begin
      timer_q   <= timer_d;
      sel_q     <= sel_d;
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
      p_q       <= p_d;
      c_q       <= c_d;
      p_valid_q <= p_valid_d;
      wrap_q    <= wrap_d;
      fd_q      <= fd_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;
  assign dp         = 1'b1;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: table-driven and scoreboard checks of the 4-digit scan controller at DIV=16, BLINK_DIV=64
module tb_seg7_scan_ctrl;
  import seg7_pkg::*;

  localparam logic [6:0] OFF = 7'h7F, DSH = 7'h3F, G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G4 = 7'h19;
  localparam logic [6:0] G5 = 7'h12, G9 = 7'h10, GM = 7'h6A, GA = 7'h08, GX = 7'h09;

  typedef logic [3:0][6:0] frame_t;
  typedef struct {
    string       name;
    mode_e       mode;
    logic [15:0] value;
    logic [27:0] raw;
    logic        blz;
    frame_t      exp;
  } vec_t;

  logic        clk = 1'b0, rst = 1'b1, load = 1'b0, blank_lz = 1'b0;
  mode_e       mode = MODE_NUM;
  logic [15:0] value = '0;
  logic [27:0] raw_seg = '0;
  logic [3:0]  blink_en = '0, bright = 4'd15;
  logic [6:0]  seg;
  logic        dp, frame_done;
  logic [3:0]  an;

  int     checks = 0, errors = 0, kcnt = 0, cnt, ph;
  logic [3:0] ea;
  frame_t exp_q[$];
  frame_t last_exp;
  vec_t   vecs[10];

  seg7_scan_ctrl #(
    .N_DIGITS  (4),
    .CLK_HZ    (1600),
    .REFRESH_HZ(100),
    .BLINK_DIV (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .mode      (mode),
    .value     (value),
    .raw_seg   (raw_seg),
    .blink_en  (blink_en),
    .blank_lz  (blank_lz),
    .bright    (bright),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) kcnt <= 0;
    else kcnt <= kcnt + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", kcnt);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_fd();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick(1);
      seen = frame_done;
    end
    chk("fd_timeout", 32'(seen), 32'd1);
  endtask

  task automatic do_load(input mode_e m, input logic [15:0] v, input logic [27:0] r,
                         input logic [3:0] b, input logic z);
    mode = m; value = v; raw_seg = r; blink_en = b; blank_lz = z; load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  // samples one full frame starting at its first displayed cycle and compares it with the scoreboard head
  task automatic capture(input string nm);
    frame_t e;
    logic [3:0] a;
    if (exp_q.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    for (int d = 0; d < 4; d++) begin
      if (d > 0) tick(16);
      a = ~(4'b0001 << d);
      chk($sformatf("%s_an%0d", nm, d), an, a);
      chk($sformatf("%s_seg%0d", nm, d), seg, e[d]);
    end
    chk({nm, "_dp"}, dp, 32'd1);
  endtask

  task automatic pwm_count(input string nm, input int want);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick(1);
      if (an != 4'hF) cnt++;
      if (i == 0) chk({nm, "_an_on"}, an, 4'hE);
      if (i == 10) chk({nm, "_seg_kept"}, seg, G2);
    end
    chk({nm, "_on_cycles"}, cnt, want);
  endtask

  initial begin
    vecs[0] = '{"num_lz",       MODE_NUM,  16'h0042, 28'h0,       1'b1, {OFF, OFF, G4, G2}};
    vecs[1] = '{"num_nolz",     MODE_NUM,  16'h0042, 28'h0,       1'b0, {G0, G0, G4, G2}};
    vecs[2] = '{"num_bcd_a",    MODE_NUM,  16'h00A0, 28'h0,       1'b0, {G0, G0, DSH, G0}};
    vecs[3] = '{"num_bcd_a_lz", MODE_NUM,  16'h00A0, 28'h0,       1'b1, {OFF, OFF, DSH, G0}};
    vecs[4] = '{"num_zero_lz",  MODE_NUM,  16'h0000, 28'h0,       1'b1, {OFF, OFF, OFF, G0}};
    vecs[5] = '{"num_inner",    MODE_NUM,  16'h9105, 28'h0,       1'b1, {G9, G1, G0, G5}};
    vecs[6] = '{"max",          MODE_MAX,  16'h0042, 28'h0,       1'b1, {GM, GA, GX, OFF}};
    vecs[7] = '{"dash",         MODE_DASH, 16'h0042, 28'h0,       1'b0, {DSH, DSH, DSH, DSH}};
    vecs[8] = '{"raw",          MODE_RAW,  16'h0042, 28'hABCDEF1, 1'b1, 28'hABCDEF1};
    vecs[9] = '{"num_top",      MODE_NUM,  16'h1000, 28'h0,       1'b1, {G1, G0, G0, G0}};

    tick(3);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, OFF);
    chk("rst_dp", dp, 1);
    chk("rst_fd", frame_done, 0);
    rst = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      tick(1);
      ea = ~(4'b0001 << ((k - 1) / 16));
      chk($sformatf("boot_%0d", k), {an, seg, frame_done}, {ea, DSH, 1'b0});
    end
    tick(1);
    chk("boot_fd", frame_done, 1);
    chk("boot_fd_an", an, 4'hE);
    tick(1);
    chk("fd_width", frame_done, 0);
    wait_fd();
    chk("fd_period", kcnt, 129);
    last_exp = {DSH, DSH, DSH, DSH};

    foreach (vecs[i]) begin
      wait_fd();
      tick(20);
      do_load(vecs[i].mode, vecs[i].value, vecs[i].raw, 4'h0, vecs[i].blz);
      chk({vecs[i].name, "_hold"}, seg, last_exp[1]);
      exp_q.push_back(vecs[i].exp);
      last_exp = vecs[i].exp;
      wait_fd();
      capture(vecs[i].name);
    end

    wait_fd();
    tick(8);
    do_load(MODE_MAX, 16'h0, 28'h0, 4'h0, 1'b0);
    tick(10);
    do_load(MODE_RAW, 16'h0, {7'h11, 7'h22, 7'h33, 7'h44}, 4'h0, 1'b0);
    last_exp = {7'h11, 7'h22, 7'h33, 7'h44};
    exp_q.push_back(last_exp);
    wait_fd();
    capture("max_then_raw");

    wait_fd();
    tick(62);
    do_load(MODE_NUM, 16'h0042, 28'h0, 4'h0, 1'b1);
    exp_q.push_back(last_exp);
    wait_fd();
    capture("wrap_load_old");
    exp_q.push_back({OFF, OFF, G4, G2});
    wait_fd();
    capture("wrap_load_new");

    bright = 4'd3;
    wait_fd();
    pwm_count("pwm_b3", 4);
    bright = 4'd0;
    wait_fd();
    pwm_count("pwm_b0", 1);
    bright = 4'd15;

    wait_fd();
    tick(20);
    do_load(MODE_NUM, 16'h0042, 28'h0, 4'b0001, 1'b1);
    for (int f = 0; f < 2; f++) begin
      wait_fd();
      ph = ((kcnt - 1) / 64) % 2;
      exp_q.push_back({OFF, OFF, G4, (ph == 1) ? OFF : G2});
      capture($sformatf("blink%0d_ph%0d", f, ph));
    end

    wait_fd();
    tick(20);
    do_load(MODE_NUM, 16'h1234, 28'h0, 4'h0, 1'b0);
    tick(5);
    rst = 1'b1;
    #1;
    chk("midrst_an", an, 4'hF);
    chk("midrst_seg", seg, OFF);
    chk("midrst_fd", frame_done, 0);
    tick(3);
    rst = 1'b0;
    exp_q.push_back({DSH, DSH, DSH, DSH});
    tick(1);
    capture("post_rst_first");
    exp_q.push_back({DSH, DSH, DSH, DSH});
    wait_fd();
    chk("post_rst_fd_cycle", kcnt, 65);
    capture("post_rst_no_pending");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised N-digit multiplexed 7-segment scan controller, successor to the team's fixed 4-digit percentage display driver. Holds a tear-free shadow copy of the display content, decodes BCD or raw glyphs per digit, and drives active-low cathodes and anodes. Adds leading-zero blanking, per-digit blink, 16-level PWM brightness and a frame-done strobe. Sits between the score/progress datapath and the Basys3 display pins.

## Interface
- N_DIGITS, 4, number of digits/anodes; legal range 3..8.
- CLK_HZ, 100_000_000, clk frequency.
- REFRESH_HZ, 1000, per-digit slot rate; DIV = CLK_HZ/REFRESH_HZ clocks per slot (≥16).
- BLINK_DIV, 50_000_000, clocks per blink half-period.
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- load  in  1  one-cycle strobe: capture mode/value/raw_seg/blink_en/blank_lz into the pending buffer.
- mode  in  2  0=NUM, 1=MAX, 2=DASH, 3=RAW.
- value  in  4*N_DIGITS  BCD digits; nibble i drives digit i (digit 0 = rightmost, an[0]).
- raw_seg  in  7*N_DIGITS  raw glyphs for RAW mode; slice i drives digit i.
- blink_en  in  N_DIGITS  per-digit blink enable.
- blank_lz  in  1  enable leading-zero blanking in NUM mode.
- bright  in  4  brightness 0..15; sampled live, not buffered.
- seg  out  7  cathodes, active low (bit 6 = g … bit 0 = a).
- dp  out  1  decimal point, active low; held 1 (off).
- an  out  N_DIGITS  anodes, active low, one-hot-zero.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit N_DIGITS-1 to 0.

## Operation
- Slot timer counts 0..DIV-1; at DIV-1 it returns to 0 and sel advances; sel wraps N_DIGITS-1 → 0, at which point frame_done pulses and the pending buffer is committed.
- Pending buffer: load copies inputs and sets pending_valid. Several loads within one frame: the last one wins. Commit happens only at the wrap cycle, and only if pending_valid is set; pending_valid then clears.
- load in the same cycle as the wrap: the current inputs are captured into pending and commit at the *next* wrap. The older pending content is discarded.
- Glyphs: 0-9 use the standard active-low codes (0=7'b1000000 … 9=7'b0010000); BCD 10-15 → DASH 7'b0111111; OFF = 7'b1111111; M = 7'b1101010, A = 7'b0001000, X = 7'b0001001.
- NUM: digit i = decode(value nibble i). With blank_lz=1, zero digits above the most significant non-zero digit show OFF; digit 0 is never blanked.
- MAX: digits N-1, N-2, N-3 show M, A, X; all other digits show OFF.
- DASH: all digits show DASH.
- RAW: digit i = raw_seg slice i.
- Blink: a free-running counter toggles phase every BLINK_DIV clocks. When phase=1, digits with committed blink_en set show OFF.
- PWM: anode enabled only while timer < ((bright+1)*DIV)>>4. Otherwise an is all-ones; seg is unaffected.

## Timing
- Reset values: an = all 1s, seg = OFF, dp = 1, frame_done = 0, sel = 0, timer = 0, blink phase = 0, pending_valid = 0, committed mode = DASH, committed blink_en = 0.
- seg, an and frame_done are registered: they reflect sel/timer with 1-cycle latency. frame_done is high in the cycle after sel becomes 0.
- Reset asserted mid-frame: all state returns to reset values immediately and any pending load is lost. Scan restarts at digit 0 on the first clock after release.
- Displayed content changes only at frame boundaries. The only exceptions are blink phase and bright, which take effect within 1 cycle.

## Structure
- Shared package seg7_pkg holds:
  - glyph constants: digits 0-9, OFF, DASH, M, A, X;
  - the 2-bit mode enum.
- Sub-module seg7_decode: combinational BCD → glyph conversion, with 10-15 mapping to DASH. It is instantiated once, on the selected digit.
- Top level contains the slot timer, sel, blink counter, pending/committed registers, PWM compare and output registers. Elaboration-time check enforces 3 ≤ N_DIGITS ≤ 8 and DIV ≥ 16.

## Test plan
Bench configuration: CLK_HZ=1600, REFRESH_HZ=100 (DIV=16), BLINK_DIV=64, N_DIGITS=4, bright=15.
- Reset release → an sequence 1110, 1101, 1011, 0111, each held 16 cycles; seg = DASH on every digit; frame_done pulses every 64 cycles.
- load mode=NUM, value=16'h0042, blank_lz=1 mid-frame → content unchanged until the next wrap; then digit 0 = 2 (0100100), digit 1 = 4 (0011001), digits 2-3 = OFF.
- Same value with blank_lz=0 → digits 2-3 = 0 (1000000). value=16'h00A0 → digit 1 = DASH, digit 0 = 0.
- load MAX and load RAW in the same frame → only RAW is committed; load asserted in the wrap cycle → commit is delayed one frame.
- bright=3 → anode low for 4 of 16 cycles per slot. blink_en=4'b0001 → digit 0 shows OFF during alternate 64-cycle phases.
- rst pulsed mid-slot with a load pending → outputs return to reset values immediately; after release the display shows DASH and the pending load is not applied.
